bp_perceptron_core: RTL and testbench

- Parametrised perceptron branch predictor core; next generation of the fixed-size predictor behind the top-level SPI trace loader.
- Generalised in history length, table depth and weight width, with a configurable training threshold.
- Serial (one weight per cycle) dot product and training FSM, driven by a valid/ready request port and an outcome port.
- Sits between the SPI deserialiser, which supplies the PC and the ground-truth direction, and the top-level status outputs.

---
 rtl/bp_pkg.sv | 32 +++
 rtl/bp_weight_sat_update.sv | 24 ++
 rtl/bp_perceptron_core.sv | 173 +++++++++++++++++
 tb/tb_bp_perceptron_core.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and sizing helpers for the perceptron branch predictor.
package bp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COMPUTE = 3'd1,
    ST_PRED    = 3'd2,
    ST_TRAIN   = 3'd3,
    ST_RETIRE  = 3'd4
  } bp_state_e;

  // Dot-product accumulator width: one extra bit per doubling of the term
  // count plus a sign bit, so the full sum can never overflow.
  function automatic int unsigned bp_acc_width(input int unsigned weight_w,
                                               input int unsigned hist_len);
    return weight_w + $clog2(hist_len + 1) + 1;
  endfunction

  // Training threshold floor(1.93*hist_len + 14), kept in integer arithmetic.
  function automatic int unsigned bp_default_theta(input int unsigned hist_len);
    return (193 * hist_len + 1400) / 100;
  endfunction

  // Table index width for a given table depth.
  function automatic int unsigned bp_idx_width(input int unsigned num_perceptrons);
    return (num_perceptrons > 1) ? $clog2(num_perceptrons) : 1;
  endfunction

  localparam int unsigned BP_NUM_PERCEPTRONS_DEF = 4;
  localparam int unsigned BP_IDX_W = bp_idx_width(BP_NUM_PERCEPTRONS_DEF);

endpackage

// File: rtl/bp_weight_sat_update.sv
// Combinational saturating weight step: w +/- 1, clamped to the signed range.
module bp_weight_sat_update #(
  parameter int unsigned WEIGHT_W = 8
) (
  input  logic [WEIGHT_W-1:0] w_i,
  input  logic                inc_i,
  output logic [WEIGHT_W-1:0] w_o
);

  localparam logic [WEIGHT_W-1:0] W_MAX = {1'b0, {(WEIGHT_W-1){1'b1}}};
  localparam logic [WEIGHT_W-1:0] W_MIN = {1'b1, {(WEIGHT_W-1){1'b0}}};
  localparam logic [WEIGHT_W-1:0] ONE   = {{(WEIGHT_W-1){1'b0}}, 1'b1};

  // Step towards the requested direction unless already at that rail.
  always_comb begin
    w_o = w_i;
    if (inc_i) begin
      if (w_i != W_MAX) w_o = w_i + ONE;
    end else begin
      if (w_i != W_MIN) w_o = w_i - ONE;
    end
  end

endmodule

// File: rtl/bp_perceptron_core.sv
// Parametrised perceptron branch predictor: serial dot product, serial
// training, one branch in flight, weights held in flops.
module bp_perceptron_core
  import bp_pkg::*;
#(
  parameter int unsigned HIST_LEN        = 8,
  parameter int unsigned NUM_PERCEPTRONS = 4,
  parameter int unsigned WEIGHT_W        = 8,
  parameter int unsigned PC_W            = 8,
  parameter int unsigned THETA           = bp_default_theta(HIST_LEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] pc_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  output logic            pred_valid_o,
  output logic            pred_taken_o,
  input  logic            outcome_valid_i,
  input  logic            outcome_taken_i,
  output logic            train_done_o,
  output logic            busy_o
);

  localparam int unsigned IDX_W = bp_idx_width(NUM_PERCEPTRONS);
  localparam int unsigned ACC_W = bp_acc_width(WEIGHT_W, HIST_LEN);
  localparam int unsigned CNT_W = $clog2(HIST_LEN + 2);
  localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(HIST_LEN);
  localparam logic [CNT_W-1:0] LAST_ACC  = CNT_W'(HIST_LEN + 1);

  bp_state_e                    state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic signed [ACC_W-1:0]      y_q, y_d;
  logic signed [WEIGHT_W:0]     term_q, term_d;
  logic                         term_vld_q, term_vld_d;
  logic                         out_q, out_d;
  logic [HIST_LEN-1:0]          hist_q, hist_d;
  logic [WEIGHT_W-1:0]          w_q [NUM_PERCEPTRONS][HIST_LEN+1];
  logic [WEIGHT_W-1:0]          w_d [NUM_PERCEPTRONS][HIST_LEN+1];

  logic [WEIGHT_W-1:0]          w_sel;
  logic [WEIGHT_W-1:0]          w_upd;
  logic signed [WEIGHT_W:0]     w_ext;
  logic [CNT_W-1:0]             cnt_m1;
  logic [HIST_LEN-1:0]          hist_sh;
  logic                         x_pos;
  logic                         y_ge0;
  logic [ACC_W-1:0]             abs_y;
  logic                         low_conf;
  logic                         mispred;
  logic                         unused_pc_bits;

  assign unused_pc_bits = ^pc_i;

  // Operand select: current row weight and input sign for step cnt_q.
  always_comb begin
    w_sel = '0;
    for (int unsigned j = 0; j <= HIST_LEN; j++) begin
      if (cnt_q == CNT_W'(j)) w_sel = w_q[idx_q][j];
    end
    cnt_m1  = cnt_q - 1'b1;
    hist_sh = hist_q >> cnt_m1;
    x_pos   = (cnt_q == '0) ? 1'b1 : hist_sh[0];
    w_ext   = {w_sel[WEIGHT_W-1], w_sel};
    y_ge0   = ~y_q[ACC_W-1];
    abs_y   = y_q[ACC_W-1] ? ACC_W'(-y_q) : ACC_W'(y_q);
    low_conf = (32'(abs_y) <= 32'(THETA));
    mispred  = (y_ge0 != outcome_taken_i);
  end

  // t*x is +1 exactly when the outcome agrees with the input sign.
  bp_weight_sat_update #(
    .WEIGHT_W(WEIGHT_W)
  ) u_sat (
    .w_i   (w_sel),
    .inc_i (out_q == x_pos),
    .w_o   (w_upd)
  );

  // Next-state logic. The +/-w term is registered one cycle before it is
  // accumulated, so COMPUTE spans one extra cycle to drain the last term.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    y_d        = y_q;
    out_d      = out_q;
    hist_d     = hist_q;
    w_d        = w_q;
    term_vld_d = (state_q == ST_COMPUTE) && (cnt_q <= LAST_TERM);
    term_d     = x_pos ? w_ext : -w_ext;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          idx_d   = pc_i[IDX_W-1:0];
          y_d     = '0;
          cnt_d   = '0;
          state_d = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        if (term_vld_q) begin
          y_d = y_q + $signed({{(ACC_W-WEIGHT_W-1){term_q[WEIGHT_W]}}, term_q});
        end
        if (cnt_q == LAST_ACC) begin
          cnt_d   = '0;
          state_d = ST_PRED;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PRED: begin
        if (outcome_valid_i) begin
          out_d   = outcome_taken_i;
          cnt_d   = '0;
          state_d = (mispred || low_conf) ? ST_TRAIN : ST_RETIRE;
        end
      end
      ST_TRAIN: begin
        for (int unsigned j = 0; j <= HIST_LEN; j++) begin
          if (cnt_q == CNT_W'(j)) w_d[idx_q][j] = w_upd;
        end
        if (cnt_q == LAST_TERM) begin
          state_d = ST_RETIRE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RETIRE: begin
        hist_d  = {hist_q[HIST_LEN-2:0], out_q};
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath and weight table registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      y_q        <= '0;
      term_q     <= '0;
      term_vld_q <= 1'b0;
      out_q      <= 1'b0;
      hist_q     <= '0;
      for (int unsigned r = 0; r < NUM_PERCEPTRONS; r++) begin
        for (int unsigned j = 0; j <= HIST_LEN; j++) begin
          w_q[r][j] <= '0;
        end
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      y_q        <= y_d;
      term_q     <= term_d;
      term_vld_q <= term_vld_d;
      out_q      <= out_d;
      hist_q     <= hist_d;
      w_q        <= w_d;
    end
  end

  assign req_ready_o  = (state_q == ST_IDLE);
  assign busy_o       = (state_q != ST_IDLE);
  assign pred_valid_o = (state_q == ST_PRED);
  assign pred_taken_o = (state_q == ST_PRED) && y_ge0;
  assign train_done_o = (state_q == ST_RETIRE);

endmodule

// File: tb/tb_bp_perceptron_core.sv
// Directed bench: three predictor configurations driven from one vector table.
module tb_bp_perceptron_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] pc_a [3];
  logic [2:0] rv_a, ov_a, ot_a;
  logic [2:0] rr_a, pv_a, pt_a, td_a, bz_a;

  int errors = 0;
  int checks = 0;

  // dut0: default sizing; dut1: narrow weights; dut2: zero threshold
  bp_perceptron_core #(.HIST_LEN(8), .NUM_PERCEPTRONS(4), .WEIGHT_W(8), .PC_W(8), .THETA(29)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .pc_i(pc_a[0]), .req_valid_i(rv_a[0]), .req_ready_o(rr_a[0]),
    .pred_valid_o(pv_a[0]), .pred_taken_o(pt_a[0]), .outcome_valid_i(ov_a[0]),
    .outcome_taken_i(ot_a[0]), .train_done_o(td_a[0]), .busy_o(bz_a[0]));

  bp_perceptron_core #(.HIST_LEN(2), .NUM_PERCEPTRONS(4), .WEIGHT_W(4), .PC_W(8), .THETA(29)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .pc_i(pc_a[1]), .req_valid_i(rv_a[1]), .req_ready_o(rr_a[1]),
    .pred_valid_o(pv_a[1]), .pred_taken_o(pt_a[1]), .outcome_valid_i(ov_a[1]),
    .outcome_taken_i(ot_a[1]), .train_done_o(td_a[1]), .busy_o(bz_a[1]));

  bp_perceptron_core #(.HIST_LEN(2), .NUM_PERCEPTRONS(4), .WEIGHT_W(8), .PC_W(8), .THETA(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .pc_i(pc_a[2]), .req_valid_i(rv_a[2]), .req_ready_o(rr_a[2]),
    .pred_valid_o(pv_a[2]), .pred_taken_o(pt_a[2]), .outcome_valid_i(ov_a[2]),
    .outcome_taken_i(ot_a[2]), .train_done_o(td_a[2]), .busy_o(bz_a[2]));

  typedef struct {
    int         dut;
    logic [7:0] pc;
    logic       outcome;
    logic       exp_taken;
    logic       exp_train;
  } vec_t;

  vec_t vecs[$];

  function automatic int hlen(input int d);
    return (d == 0) ? 8 : 2;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic add(input int d, input logic [7:0] p, input logic o,
                     input logic et, input logic tr);
    vec_t v;
    v.dut = d; v.pc = p; v.outcome = o; v.exp_taken = et; v.exp_train = tr;
    vecs.push_back(v);
  endtask

  // Handshake a request, then count edges until the prediction appears.
  task automatic request(input int d, input logic [7:0] p, output logic taken,
                         output int plat, output logic bz_ok);
    int n;
    @(negedge clk);
    check("ready_before_req", int'(rr_a[d]), 1);
    pc_a[d] = p;
    rv_a[d] = 1'b1;
    @(negedge clk);
    rv_a[d] = 1'b0;
    n = 0;
    bz_ok = 1'b1;
    while (!pv_a[d] && n < 60) begin
      if (!bz_a[d] || rr_a[d]) bz_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    plat  = n;
    taken = pt_a[d];
  endtask

  // Present the outcome while the prediction is held; measure retire latency.
  task automatic resolve(input int d, input logic o, output int dlat);
    int m;
    ot_a[d] = o;
    ov_a[d] = 1'b1;
    @(negedge clk);
    ov_a[d] = 1'b0;
    check("pred_drop", int'(pv_a[d]), 0);
    m = 1;
    while (!td_a[d] && m < 60) begin
      @(negedge clk);
      m++;
    end
    dlat = m;
    @(negedge clk);
    check("done_pulse_width", int'(td_a[d]), 0);
  endtask

  initial begin
    logic taken;
    logic bz_ok;
    int   plat;
    int   dlat;

    // dut0: train towards not-taken, index isolation on row 1
    add(0, 8'h00, 1'b0, 1'b1, 1'b1);   // y=0
    add(0, 8'h00, 1'b0, 1'b0, 1'b1);   // y=-9
    add(0, 8'h01, 1'b1, 1'b1, 1'b1);   // row 1 untouched: y=0
    add(0, 8'h00, 1'b0, 1'b0, 1'b1);   // y=-14
    // dut1: 13 not-taken outcomes; bias must clamp at -8, weights at +7
    for (int i = 0; i < 13; i++) add(1, 8'h00, 1'b0, (i == 0), 1'b1);
    // dut2: trained, confident skip (|y|=1 > 0), then mispredict (y=-1)
    add(2, 8'h00, 1'b1, 1'b1, 1'b1);
    add(2, 8'h00, 1'b1, 1'b1, 1'b0);
    add(2, 8'h00, 1'b1, 1'b0, 1'b1);

    rst_n = 1'b0;
    rv_a = '0; ov_a = '0; ot_a = '0;
    for (int i = 0; i < 3; i++) pc_a[i] = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++)
      check("reset_state", int'({rr_a[i], pv_a[i], pt_a[i], td_a[i], bz_a[i]}), 16);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      request(vecs[k].dut, vecs[k].pc, taken, plat, bz_ok);
      check($sformatf("pred_latency[%0d]", k), plat, hlen(vecs[k].dut) + 2);
      check($sformatf("busy_not_ready[%0d]", k), int'(bz_ok), 1);
      check($sformatf("pred_taken[%0d]", k), int'(taken), int'(vecs[k].exp_taken));
      resolve(vecs[k].dut, vecs[k].outcome, dlat);
      check($sformatf("done_latency[%0d]", k), dlat,
            vecs[k].exp_train ? hlen(vecs[k].dut) + 2 : 1);
    end

    // Reset in the middle of TRAIN on dut0 (y=-19, outcome taken mispredicts)
    request(0, 8'h00, taken, plat, bz_ok);
    check("pre_reset_pred", int'(taken), 0);
    ot_a[0] = 1'b1;
    ov_a[0] = 1'b1;
    @(negedge clk);
    ov_a[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("busy_in_train", int'(bz_a[0]), 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", int'({rr_a[0], pv_a[0], pt_a[0], td_a[0], bz_a[0]}), 16);
    @(negedge clk);
    rst_n = 1'b1;
    ov_a[0] = 1'b1;
    ot_a[0] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stray_outcome_idle", int'({pv_a[0], bz_a[0], td_a[0]}), 0);
    end
    ov_a[0] = 1'b0;
    request(0, 8'h00, taken, plat, bz_ok);
    check("post_reset_latency", plat, 10);
    check("post_reset_taken", int'(taken), 1);
    resolve(0, 1'b1, dlat);
    check("post_reset_done_latency", dlat, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
